rdmx_frame_gen: RTL and testbench

Synthetic RDMX traffic source for the NSDP checker bench. For each frame it consumes one 32-bit data pattern and emits one half-frame of RDMX traffic on a 512-bit AXI stream: N frame-data packets, then one meta-data packet, then one frame-counter packet. It also forwards each pattern on a side stream that feeds the checker's pattern input. It sits directly upstream of the data checker, in place of the CMAC receive path.

---
 rtl/rdmx_frame_gen.sv | 209 ++++++++++++++++++++
 tb/tb_rdmx_frame_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rdmx_frame_gen.sv
// rdmx_frame_gen: synthetic RDMX half-frame traffic source (FD packets, meta-data, frame counter)
// with a forwarded copy of each frame's pattern for the downstream checker.
module rdmx_frame_gen #(
    parameter logic [15:0] RDMX_MAGIC      = 16'h0122,
    parameter int          PACKET_OVERHEAD = 50
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [31:0]  frame_limit,
    input  logic [31:0]  first_fc,
    input  logic [15:0]  PACKET_SIZE,
    input  logic [31:0]  FRAME_SIZE,
    input  logic [31:0]  axis_pat_in_tdata,
    input  logic         axis_pat_in_tvalid,
    output logic         axis_pat_in_tready,
    output logic [31:0]  axis_pat_out_tdata,
    output logic         axis_pat_out_tvalid,
    input  logic         axis_pat_out_tready,
    output logic [511:0] axis_eth_tdata,
    output logic         axis_eth_tvalid,
    output logic         axis_eth_tlast,
    input  logic         axis_eth_tready,
    output logic         busy,
    output logic [31:0]  frames_sent,
    output logic         config_error
);
    typedef enum logic [2:0] {IDLE, GET_PAT, FD_HDR, FD_DATA, MD_HDR, MD_DATA, FC_HDR, FC_DATA} state_t;

    state_t       state_q, state_d;
    logic [15:0]  psize_q, psize_d;
    logic [31:0]  pph_q, pph_d, fd_count_q, fd_count_d, fc_next_q, fc_next_d;
    logic [31:0]  frames_q, frames_d, pat_q, pat_d, pout_data_q, pout_data_d;
    logic [7:0]   dcyc_q, dcyc_d, beat_q, beat_d;
    logic         busy_q, busy_d, cfg_err_q, cfg_err_d, pout_valid_q, pout_valid_d;
    logic         eth_valid_q, eth_valid_d, eth_last_q, eth_last_d, fc_pend_q, fc_pend_d;
    logic [511:0] eth_data_q, eth_data_d;
    logic [3:0]   sh;
    logic         legal, eth_adv, eth_hs, fd_last;
    logic [31:0]  pph_c;

    function automatic logic [511:0] hdr(input logic [15:0] len);
        logic [511:0] h;
        h = '0;
        h[12*8 +: 8] = 8'h08;
        h[16*8 +: 8] = len[15:8];
        h[17*8 +: 8] = len[7:0];
        h[42*8 +: 8] = RDMX_MAGIC[15:8];
        h[43*8 +: 8] = RDMX_MAGIC[7:0];
        return h;
    endfunction

    always_comb begin
        legal = 1'b1;
        sh = 4'd6;
        case (PACKET_SIZE)
            16'd64:   sh = 4'd6;
            16'd128:  sh = 4'd7;
            16'd256:  sh = 4'd8;
            16'd512:  sh = 4'd9;
            16'd1024: sh = 4'd10;
            16'd2048: sh = 4'd11;
            16'd4096: sh = 4'd12;
            16'd8192: sh = 4'd13;
            default:  legal = 1'b0;
        endcase
        pph_c = (FRAME_SIZE >> sh) >> 1;
    end

    assign axis_pat_in_tready = (state_q == GET_PAT) && !pout_valid_q;
    // The output register is a skid slot: the FSM may refill it whenever it is empty or draining.
    assign eth_adv = !eth_valid_q || axis_eth_tready;
    assign eth_hs  = eth_valid_q && axis_eth_tready;
    assign fd_last = beat_q == dcyc_q - 8'd1;

    always_comb begin
        state_d      = state_q;
        psize_d      = psize_q;
        pph_d        = pph_q;
        dcyc_d       = dcyc_q;
        beat_d       = beat_q;
        fd_count_d   = fd_count_q;
        fc_next_d    = fc_next_q;
        frames_d     = frames_q;
        pat_d        = pat_q;
        busy_d       = busy_q;
        cfg_err_d    = cfg_err_q;
        fc_pend_d    = fc_pend_q;
        pout_data_d  = pout_data_q;
        pout_valid_d = pout_valid_q && !axis_pat_out_tready;
        eth_valid_d  = eth_valid_q && !eth_hs;
        eth_data_d   = eth_data_q;
        eth_last_d   = eth_last_q;
        case (state_q)
            IDLE: if (start) begin
                if (!legal || pph_c == 32'd0) cfg_err_d = 1'b1;
                else begin
                    cfg_err_d = 1'b0;
                    frames_d  = '0;
                    fc_next_d = first_fc;
                    busy_d    = 1'b1;
                    psize_d   = PACKET_SIZE;
                    pph_d     = pph_c;
                    dcyc_d    = PACKET_SIZE[13:6];
                    state_d   = GET_PAT;
                end
            end
            GET_PAT: if (axis_pat_in_tvalid && axis_pat_in_tready) begin
                pat_d        = axis_pat_in_tdata;
                pout_data_d  = axis_pat_in_tdata;
                pout_valid_d = 1'b1;
                fd_count_d   = '0;
                state_d      = FD_HDR;
            end
            FD_HDR: if (eth_adv) begin
                {eth_valid_d, eth_last_d, eth_data_d} = {2'b10, hdr(psize_q + 16'(PACKET_OVERHEAD))};
                beat_d  = '0;
                state_d = FD_DATA;
            end
            FD_DATA: if (eth_adv) begin
                {eth_valid_d, eth_last_d, eth_data_d} = {1'b1, fd_last, {16{pat_q}}};
                beat_d = beat_q + 8'd1;
                if (fd_last) begin
                    fd_count_d = fd_count_q + 32'd1;
                    state_d    = (fd_count_q + 32'd1 == pph_q) ? MD_HDR : FD_HDR;
                end
            end
            MD_HDR: if (eth_adv) begin
                {eth_valid_d, eth_last_d, eth_data_d} = {2'b10, hdr(16'(PACKET_OVERHEAD + 128))};
                beat_d  = '0;
                state_d = MD_DATA;
            end
            MD_DATA: if (eth_adv) begin
                {eth_valid_d, eth_last_d, eth_data_d} = {1'b1, beat_q == 8'd1, 512'b0};
                beat_d  = beat_q + 8'd1;
                state_d = (beat_q == 8'd1) ? FC_HDR : MD_DATA;
            end
            FC_HDR: if (eth_adv) begin
                {eth_valid_d, eth_last_d, eth_data_d} = {2'b10, hdr(16'(PACKET_OVERHEAD + 4))};
                state_d = FC_DATA;
            end
            FC_DATA: begin
                // Counters move only once the FC beat has actually left the skid slot.
                if (!fc_pend_q && eth_adv) begin
                    {eth_valid_d, eth_last_d, eth_data_d} = {2'b11, 480'b0, fc_next_q};
                    fc_pend_d = 1'b1;
                end else if (fc_pend_q && eth_hs) begin
                    fc_pend_d = 1'b0;
                    fc_next_d = fc_next_q + 32'd1;
                    frames_d  = frames_q + 32'd1;
                    if (frame_limit != 32'd0 && frames_q + 32'd1 == frame_limit) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else state_d = GET_PAT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            psize_q      <= '0;
            pph_q        <= '0;
            dcyc_q       <= '0;
            beat_q       <= '0;
            fd_count_q   <= '0;
            fc_next_q    <= '0;
            frames_q     <= '0;
            pat_q        <= '0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            fc_pend_q    <= 1'b0;
            pout_valid_q <= 1'b0;
            pout_data_q  <= '0;
            eth_valid_q  <= 1'b0;
            eth_last_q   <= 1'b0;
            eth_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            psize_q      <= psize_d;
            pph_q        <= pph_d;
            dcyc_q       <= dcyc_d;
            beat_q       <= beat_d;
            fd_count_q   <= fd_count_d;
            fc_next_q    <= fc_next_d;
            frames_q     <= frames_d;
            pat_q        <= pat_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            fc_pend_q    <= fc_pend_d;
            pout_valid_q <= pout_valid_d;
            pout_data_q  <= pout_data_d;
            eth_valid_q  <= eth_valid_d;
            eth_last_q   <= eth_last_d;
            eth_data_q   <= eth_data_d;
        end
    end

    assign axis_pat_out_tdata  = pout_data_q;
    assign axis_pat_out_tvalid = pout_valid_q;
    assign axis_eth_tdata      = eth_data_q;
    assign axis_eth_tvalid     = eth_valid_q;
    assign axis_eth_tlast      = eth_last_q;
    assign busy                = busy_q;
    assign frames_sent         = frames_q;
    assign config_error        = cfg_err_q;
endmodule

// File: tb/tb_rdmx_frame_gen.sv
// tb_rdmx_frame_gen: directed runs of rdmx_frame_gen against a beat scoreboard built from the
// packet format, with optional random backpressure and pattern-source gaps.
module tb_rdmx_frame_gen;
    typedef struct packed {
        logic         last;
        logic [511:0] data;
    } beat_t;

    logic         clk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic [31:0]  frame_limit = '0, first_fc = '0, fsize = 32'd2048;
    logic [15:0]  psize = 16'd256;
    logic [31:0]  pin_data = '0, pout_data;
    logic         pin_valid = 1'b0, pin_ready, pout_valid, pout_ready = 1'b1;
    logic [511:0] eth_data;
    logic         eth_valid, eth_last, eth_ready = 1'b1;
    logic         busy, config_error;
    logic [31:0]  frames_sent;

    beat_t       exp_q[$];
    logic [31:0] src_q[$];
    logic [31:0] pexp_q[$];
    int          checks = 0, errors = 0, hs_cnt = 0;
    bit          rnd = 1'b0, taken = 1'b0, stalled = 1'b0;
    beat_t       held;

    rdmx_frame_gen dut (
        .clk(clk), .resetn(resetn), .start(start), .frame_limit(frame_limit), .first_fc(first_fc),
        .PACKET_SIZE(psize), .FRAME_SIZE(fsize),
        .axis_pat_in_tdata(pin_data), .axis_pat_in_tvalid(pin_valid), .axis_pat_in_tready(pin_ready),
        .axis_pat_out_tdata(pout_data), .axis_pat_out_tvalid(pout_valid), .axis_pat_out_tready(pout_ready),
        .axis_eth_tdata(eth_data), .axis_eth_tvalid(eth_valid), .axis_eth_tlast(eth_last),
        .axis_eth_tready(eth_ready), .busy(busy), .frames_sent(frames_sent), .config_error(config_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] hdr(input logic [15:0] len);
        logic [511:0] h;
        h = '0;
        h[12*8 +: 8] = 8'h08;
        h[16*8 +: 8] = len[15:8];
        h[17*8 +: 8] = len[7:0];
        h[42*8 +: 8] = 8'h01;
        h[43*8 +: 8] = 8'h22;
        return h;
    endfunction

    task automatic push(input logic l, input logic [511:0] d);
        beat_t b;
        b = {l, d};
        exp_q.push_back(b);
    endtask

    // One frame: its pattern goes to the source queue, its expected beats to the scoreboard.
    task automatic add_frame(input int ps, input int fs, input logic [31:0] fc, input logic [31:0] pat);
        int pph, dc;
        pph = (fs / ps) / 2;
        dc  = ps / 64;
        src_q.push_back(pat);
        for (int k = 0; k < pph; k++) begin
            push(1'b0, hdr(16'(ps + 50)));
            for (int b = 0; b < dc; b++) push(b == dc - 1, {16{pat}});
        end
        push(1'b0, hdr(16'd178));
        push(1'b0, '0);
        push(1'b1, '0);
        push(1'b0, hdr(16'd54));
        push(1'b1, {480'b0, fc});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, input bit want_idle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || (want_idle && busy)) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < bound, 1'b1);
        chk({tag, "_pat_fwd"}, pexp_q.size(), 0);
    endtask

    // Input driver: changes just after the active edge; valid held until taken.
    initial forever begin
        @(posedge clk);
        #1;
        eth_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (src_q.size() == 0) pin_valid = 1'b0;
        else begin
            if (!(pin_valid && !taken)) pin_valid = !rnd || $urandom_range(0, 1) == 1;
            pin_data = src_q[0];
        end
        taken = 1'b0;
    end

    // Monitor on the falling edge: a valid&&ready seen here completes at the next rising edge.
    initial forever begin
        beat_t       e;
        logic [31:0] pe;
        @(negedge clk);
        if (!resetn) stalled = 1'b0;
        else begin
            if (stalled) begin
                checks++;
                assert (eth_valid && {eth_last, eth_data} === held) else begin
                    errors++;
                    $error("FAIL stall_hold: observed valid=%0b %h expected %h", eth_valid, {eth_last, eth_data}, held);
                end
            end
            if (eth_valid && eth_ready) begin
                hs_cnt++;
                e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                checks++;
                assert ({eth_last, eth_data} === e) else begin
                    errors++;
                    $error("FAIL eth_beat %0d: observed %h expected %h", hs_cnt, {eth_last, eth_data}, e);
                end
            end
            stalled = eth_valid && !eth_ready;
            held = {eth_last, eth_data};
            if (pin_valid && pin_ready && src_q.size() != 0) begin
                pexp_q.push_back(src_q.pop_front());
                taken = 1'b1;
            end
            if (pout_valid && pout_ready) begin
                pe = pexp_q.size() != 0 ? pexp_q.pop_front() : 'x;
                chk("pat_out", pout_data, pe);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, n, seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_eth_valid", eth_valid, 0);
        chk("rst_eth_last", eth_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_cfg_err", config_error, 0);
        chk("rst_pat_out_valid", pout_valid, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // Basic run, full throughput.
        first_fc = 32'd5; frame_limit = 32'd1;
        h = hs_cnt;
        add_frame(256, 2048, 32'd5, 32'hA5A5_0001);
        pulse_start();
        wait_done("run1", 2000, 1'b1);
        chk("run1_beats", hs_cnt - h, 25);
        chk("run1_frames", frames_sent, 1);
        chk("run1_busy", busy, 0);

        // Same shape under random backpressure and source gaps.
        rnd = 1'b1; frame_limit = 32'd3;
        for (int i = 0; i < 3; i++) add_frame(256, 2048, 32'(5 + i), 32'hC0DE_0000 + 32'(i));
        pulse_start();
        wait_done("run_rnd", 5000, 1'b1);
        chk("run_rnd_frames", frames_sent, 3);
        rnd = 1'b0;

        // Illegal configurations.
        fsize = 32'd256;
        pulse_start();
        @(negedge clk);
        chk("pph0_cfg_err", config_error, 1);
        chk("pph0_busy", busy, 0);
        fsize = 32'd2048; psize = 16'd100;
        pulse_start();
        @(negedge clk);
        chk("bad_size_cfg_err", config_error, 1);
        chk("bad_size_busy", busy, 0);
        seen = 0;
        repeat (10) begin @(negedge clk); seen += int'(eth_valid); end
        chk("bad_size_no_valid", seen, 0);
        psize = 16'd256; first_fc = 32'd9; frame_limit = 32'd1;
        add_frame(256, 2048, 32'd9, 32'h1234_5678);
        pulse_start();
        @(negedge clk);
        chk("legal_clears_cfg_err", config_error, 0);
        chk("legal_busy", busy, 1);
        wait_done("run_after_err", 2000, 1'b1);

        // Smallest packets with frame-counter wrap.
        psize = 16'd64; fsize = 32'd128; first_fc = 32'hFFFF_FFFF; frame_limit = 32'd2;
        add_frame(64, 128, 32'hFFFF_FFFF, 32'h0000_00AA);
        add_frame(64, 128, 32'h0000_0000, 32'h0000_00BB);
        pulse_start();
        wait_done("run_wrap", 2000, 1'b1);
        chk("run_wrap_frames", frames_sent, 2);

        // Largest packets.
        psize = 16'd8192; fsize = 32'd16384; first_fc = 32'd77; frame_limit = 32'd1;
        add_frame(8192, 16384, 32'd77, 32'hFEED_BEEF);
        pulse_start();
        wait_done("run_8k", 2000, 1'b1);

        // Reset in the middle of a frame-data packet.
        psize = 16'd256; fsize = 32'd2048; first_fc = 32'd5; frame_limit = 32'd1;
        add_frame(256, 2048, 32'd5, 32'h5555_AAAA);
        pulse_start();
        h = hs_cnt; n = 0;
        while (hs_cnt < h + 2 && n < 200) begin @(negedge clk); n++; end
        chk("mid_reset_reach", n < 200, 1'b1);
        @(posedge clk); #1 resetn = 1'b0;
        exp_q.delete(); src_q.delete(); pexp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_valid", eth_valid, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_pat_valid", pout_valid, 0);
        @(posedge clk); #1 resetn = 1'b1;
        add_frame(256, 2048, 32'd5, 32'h0F0F_0F0F);
        pulse_start();
        wait_done("run_post_reset", 2000, 1'b1);
        chk("run_post_reset_frames", frames_sent, 1);

        // Free-running: 100 frames then the source dries up.
        rnd = 1'b1; frame_limit = 32'd0;
        for (int i = 0; i < 100; i++) add_frame(256, 2048, 32'(5 + i), 32'(i));
        pulse_start();
        wait_done("run_forever", 30000, 1'b0);
        repeat (5) @(negedge clk);
        chk("forever_frames", frames_sent, 100);
        chk("forever_busy", busy, 1);
        chk("forever_idle_valid", eth_valid, 0);
        rnd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
